// File: rtl/nic_tx_arbiter.sv
// nic_tx_arbiter: round-robin arbiter granting one host requester per packet
// and forwarding its flits into the NIC push port under nic_we backpressure.
// Optional feature macro: NIC_ARB_WATCHDOG_EN (stall watchdog with ABORT state).
module nic_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FLIT_WIDTH  = 64,
    parameter int unsigned MAX_FLITS   = 16,
    parameter int unsigned STALL_LIMIT = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0]   req_flit,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            nic_we,
    output logic [FLIT_WIDTH-1:0]           flit_out,
    output logic                            push_out,
    output logic                            grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [$clog2(MAX_FLITS+1)-1:0]  flit_cnt,
    output logic [15:0]                     pkt_count,
    output logic                            err_pulse
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(MAX_FLITS+1);

`ifdef NIC_ARB_WATCHDOG_EN
    localparam int unsigned SW = $clog2(STALL_LIMIT+1);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ABORT} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_XFER} state_t;
`endif

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic [CNTW-1:0]   flit_cnt_q, flit_cnt_d;
    logic [15:0]       pkt_count_q, pkt_count_d;
`ifdef NIC_ARB_WATCHDOG_EN
    logic [SW-1:0]     stall_q, stall_d;
`endif

    logic                  pick_found;
    logic [IDW-1:0]        pick_id;
    logic [IDW-1:0]        cand;
    logic                  g_valid;
    logic                  g_last;
    logic [FLIT_WIDTH-1:0] g_flit;
    logic [IDW-1:0]        next_id;

    // Select the granted requester's lane and the successor id for rr_ptr
    always_comb begin
        g_valid = req_valid[grant_id_q];
        g_last  = req_last[grant_id_q];
        g_flit  = req_flit[grant_id_q*FLIT_WIDTH +: FLIT_WIDTH];
        next_id = (grant_id_q == IDW'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;
    end

    // First valid requester in search order rr_ptr, rr_ptr+1, ... mod NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state, bookkeeping and combinational push-path outputs
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        flit_cnt_d    = flit_cnt_q;
        pkt_count_d   = pkt_count_q;
`ifdef NIC_ARB_WATCHDOG_EN
        stall_d       = stall_q;
`endif
        req_ready     = '0;
        push_out      = 1'b0;
        flit_out      = '0;
        err_pulse     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d       = S_XFER;
                    grant_id_d    = pick_id;
                    grant_valid_d = 1'b1;
                    flit_cnt_d    = '0;
`ifdef NIC_ARB_WATCHDOG_EN
                    stall_d       = '0;
`endif
                end
            end

            S_XFER: begin
                // rst gates the push so an abandoned packet loses no flit
                if (g_valid && nic_we && !rst) begin
                    req_ready[grant_id_q] = 1'b1;
                    push_out              = 1'b1;
                    flit_out              = g_flit;
                    flit_cnt_d            = flit_cnt_q + 1'b1;
                    // The MAX_FLITS-th flit closes the packet even without req_last
                    if (g_last || (flit_cnt_q == CNTW'(MAX_FLITS-1))) begin
                        state_d       = S_IDLE;
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = next_id;
                        if (g_last) begin
                            pkt_count_d = pkt_count_q + 16'd1;
                        end else begin
                            err_pulse   = 1'b1;
                        end
                    end
                end
`ifdef NIC_ARB_WATCHDOG_EN
                // Only a missing requester flit counts; NIC backpressure does not
                if (!g_valid) begin
                    if (stall_q == SW'(STALL_LIMIT-1)) begin
                        state_d       = S_ABORT;
                        grant_valid_d = 1'b0;
                        rr_ptr_d      = next_id;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end else begin
                    stall_d = '0;
                end
`endif
            end

`ifdef NIC_ARB_WATCHDOG_EN
            S_ABORT: begin
                err_pulse = 1'b1;
                state_d   = S_IDLE;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and statistics registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            flit_cnt_q    <= '0;
            pkt_count_q   <= '0;
`ifdef NIC_ARB_WATCHDOG_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            flit_cnt_q    <= flit_cnt_d;
            pkt_count_q   <= pkt_count_d;
`ifdef NIC_ARB_WATCHDOG_EN
            stall_q       <= stall_d;
`endif
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign flit_cnt    = flit_cnt_q;
    assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_nic_tx_arbiter.sv
// Directed scoreboard bench for nic_tx_arbiter (NUM_REQ=4, 64-bit flits,
// MAX_FLITS=16, STALL_LIMIT=32). Watchdog scenario depends on NIC_ARB_WATCHDOG_EN.
module tb_nic_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned FW = 64;
    localparam int unsigned MF = 16;
    localparam int unsigned SL = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*FW-1:0]  req_flit;
    logic [NR-1:0]     req_ready;
    logic              nic_we;
    logic [FW-1:0]     flit_out;
    logic              push_out;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [4:0]        flit_cnt;
    logic [15:0]       pkt_count;
    logic              err_pulse;

    always #5 clk = ~clk;

    nic_tx_arbiter #(
        .NUM_REQ(NR), .FLIT_WIDTH(FW), .MAX_FLITS(MF), .STALL_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_flit(req_flit),
        .req_ready(req_ready), .nic_we(nic_we),
        .flit_out(flit_out), .push_out(push_out),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .flit_cnt(flit_cnt), .pkt_count(pkt_count), .err_pulse(err_pulse)
    );

    typedef struct {
        logic [FW-1:0] d;
        logic          l;
    } flit_t;

    flit_t         rq_q [NR][$];   // per-requester pending flits
    logic [FW-1:0] want_q [$];     // flits the NIC is expected to receive, in order
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic add_pkt(input int r, input int n, input bit last, input int nexp);
        flit_t f;
        for (int k = 0; k < n; k++) begin
            f.d = {$urandom, $urandom};
            f.l = last && (k == n-1);
            rq_q[r].push_back(f);
            if (k < nexp) want_q.push_back(f.d);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rq_q[i].size() > 0) begin
                req_valid[i]         = 1'b1;
                req_flit[i*FW +: FW] = rq_q[i][0].d;
                req_last[i]          = rq_q[i][0].l;
            end else begin
                req_valid[i]         = 1'b0;
                req_flit[i*FW +: FW] = '0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample combinational outputs mid-cycle, score pushes,
    // retire consumed flits, then advance to the next falling edge.
    task automatic step(output logic p, output logic e, output logic [NR-1:0] r);
        drive();
        #1;
        p = push_out;
        e = err_pulse;
        r = req_ready;
        check("push_without_we", push_out & ~nic_we, 0);
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("ready_vs_push", |req_ready, push_out);
        if (push_out) begin
            if (want_q.size() == 0) check("push_when_none_expected", push_out, 0);
            else check("flit_out", flit_out, want_q.pop_front());
        end else begin
            check("flit_out_idle_zero", flit_out, 0);
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                check("ready_has_valid", req_valid[i], 1);
                if (rq_q[i].size() > 0) void'(rq_q[i].pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        logic p, e;
        logic [NR-1:0] r;
        check("drained_before_reset", want_q.size(), 0);
        rst    = 1'b1;
        nic_we = 1'b1;
        for (int i = 0; i < NR; i++) rq_q[i].delete();
        want_q.delete();
        step(p, e, r);
        step(p, e, r);
        rst = 1'b0;
    endtask

    initial begin
        logic          p, e;
        logic [NR-1:0] r;
        int            errs;

        rst = 1'b1; nic_we = 1'b1;
        req_valid = '0; req_last = '0; req_flit = '0;
        step(p, e, r);
        step(p, e, r);
        check("rst_req_ready",   req_ready,   0);
        check("rst_flit_out",    flit_out,    0);
        check("rst_push_out",    push_out,    0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id",    grant_id,    0);
        check("rst_flit_cnt",    flit_cnt,    0);
        check("rst_pkt_count",   pkt_count,   0);
        check("rst_err_pulse",   err_pulse,   0);
        rst = 1'b0;

        // Single requester, 3-flit packet
        add_pkt(2, 3, 1, 3);
        step(p, e, r);
        check("t1_idle_nopush", p, 0);
        check("t1_grant_id", grant_id, 2);
        check("t1_grant_valid", grant_valid, 1);
        for (int k = 0; k < 3; k++) begin
            step(p, e, r);
            check("t1_push", p, 1);
            check("t1_ready", r, 4'b0100);
            check("t1_grant_id_xfer", grant_id, 2);
        end
        check("t1_pkt_count", pkt_count, 1);
        check("t1_grant_released", grant_valid, 0);
        check("t1_flit_cnt", flit_cnt, 3);

        // Fairness: grants rotate 0,1,2,3,0
        do_reset();
        add_pkt(0, 1, 1, 1);
        add_pkt(1, 1, 1, 1);
        add_pkt(2, 1, 1, 1);
        add_pkt(3, 1, 1, 1);
        add_pkt(0, 1, 1, 1);
        for (int k = 0; k < 5; k++) begin
            step(p, e, r);
            check("t2_idle_nopush", p, 0);
            check("t2_grant_id", grant_id, k % 4);
            step(p, e, r);
            check("t2_push", p, 1);
        end
        check("t2_pkt_count", pkt_count, 5);

        // Backpressure mid-packet
        do_reset();
        add_pkt(1, 4, 1, 4);
        step(p, e, r);
        check("t3_idle_nopush", p, 0);
        for (int k = 0; k < 2; k++) begin
            step(p, e, r);
            check("t3_push_pre", p, 1);
        end
        nic_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(p, e, r);
            check("t3_bp_nopush", p, 0);
            check("t3_bp_ready", r, 0);
        end
        check("t3_cnt_hold", flit_cnt, 2);
        nic_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(p, e, r);
            check("t3_push_post", p, 1);
        end
        check("t3_flit_cnt", flit_cnt, 4);
        check("t3_pkt_count", pkt_count, 1);

        // Oversize packet: 20 flits without tail, cut at 16
        do_reset();
        add_pkt(0, 20, 0, MF);
        add_pkt(1, 1, 1, 1);
        step(p, e, r);
        check("t4_grant_id", grant_id, 0);
        for (int k = 0; k < MF; k++) begin
            step(p, e, r);
            check("t4_push", p, 1);
            check("t4_err", e, (k == MF-1));
        end
        check("t4_pkt_unchanged", pkt_count, 0);
        check("t4_grant_released", grant_valid, 0);
        check("t4_flit_cnt", flit_cnt, MF);
        step(p, e, r);
        check("t4_next_grant", grant_id, 1);
        step(p, e, r);
        check("t4_next_push", p, 1);
        check("t4_pkt_after", pkt_count, 1);

        // Reset mid-packet after 2 of 5 flits
        do_reset();
        add_pkt(2, 5, 1, 2);
        step(p, e, r);
        check("t5_grant_id", grant_id, 2);
        step(p, e, r);
        step(p, e, r);
        check("t5_cnt_mid", flit_cnt, 2);
        rst = 1'b1;
        step(p, e, r);
        check("t5_rst_nopush", p, 0);
        check("t5_rst_noready", r, 0);
        check("t5_req_ready",   req_ready,   0);
        check("t5_flit_out",    flit_out,    0);
        check("t5_push_out",    push_out,    0);
        check("t5_grant_valid", grant_valid, 0);
        check("t5_grant_id0",   grant_id,    0);
        check("t5_flit_cnt",    flit_cnt,    0);
        check("t5_pkt_count",   pkt_count,   0);
        check("t5_err_pulse",   err_pulse,   0);
        rq_q[2].delete();
        rst = 1'b0;
        add_pkt(0, 1, 1, 1);
        add_pkt(2, 1, 1, 1);
        step(p, e, r);
        check("t5_new_grant0", grant_id, 0);
        step(p, e, r);
        check("t5_push0", p, 1);
        step(p, e, r);
        check("t5_new_grant2", grant_id, 2);
        step(p, e, r);
        check("t5_push2", p, 1);
        check("t5_pkt_after", pkt_count, 2);

`ifdef NIC_ARB_WATCHDOG_EN
        // Watchdog: granted requester stalls for STALL_LIMIT cycles
        do_reset();
        add_pkt(3, 1, 0, 1);
        step(p, e, r);
        check("t6_grant_id", grant_id, 3);
        step(p, e, r);
        check("t6_first_push", p, 1);
        add_pkt(1, 1, 1, 1);
        errs = 0;
        for (int k = 0; k < SL; k++) begin
            step(p, e, r);
            check("t6_stall_nopush", p, 0);
            errs += int'(e);
        end
        check("t6_abort_grant_valid", grant_valid, 0);
        check("t6_abort_err", err_pulse, 1);
        step(p, e, r);
        errs += int'(e);
        step(p, e, r);
        errs += int'(e);
        check("t6_err_once", errs, 1);
        check("t6_next_grant", grant_id, 1);
        step(p, e, r);
        check("t6_next_push", p, 1);
        check("t6_pkt_count", pkt_count, 1);
`else
        // No watchdog: a stalled requester keeps the grant
        do_reset();
        add_pkt(3, 1, 0, 1);
        step(p, e, r);
        check("t6_grant_id", grant_id, 3);
        step(p, e, r);
        check("t6_first_push", p, 1);
        errs = 0;
        for (int k = 0; k < SL + 8; k++) begin
            step(p, e, r);
            errs += int'(e);
        end
        check("t6_no_err", errs, 0);
        check("t6_grant_held", grant_valid, 1);
        check("t6_grant_id_held", grant_id, 3);
        add_pkt(3, 1, 1, 1);
        step(p, e, r);
        check("t6_tail_push", p, 1);
        check("t6_released", grant_valid, 0);
        check("t6_flit_cnt", flit_cnt, 2);
        check("t6_pkt_count", pkt_count, 1);
`endif

        check("final_drained", want_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
